flexbex_ibex_prefetch_queue: RTL
================================

// Module: flexbex_ibex_prefetch_queue
// PURPOSE
//  Upstream neighbour of the IF stage: fetches 32-bit words from instruction memory via req/gnt/rvalid.
//  Buffers the words in a small FIFO.
//  Realigns them into a halfword stream so that one RV32IC instruction (16- or 32-bit, possibly
//  straddling a word) is presented per ready/valid transfer.
//  Handles branches: flushes the FIFO and discards any in-flight response.
// PARAMETERS
//  DEPTH  3  FIFO entries, in 32-bit words. Legal range is 2..8; 2 is the minimum that covers unaligned 32-bit instructions.
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   async reset, active low
//  req_i           in   1   fetch enable; when low, no new memory requests are issued
//  branch_i        in   1   redirect fetch to addr_i this cycle
//  addr_i          in   32  branch target, halfword aligned (bit0 = 0)
//  ready_i         in   1   IF stage consumes the current instruction
//  valid_o         out  1   rdata_o/addr_o hold a complete instruction
//  rdata_o         out  32  instruction; a compressed one occupies [15:0], upper bits don't-care
//  addr_o          out  32  PC of rdata_o
//  instr_req_o     out  1   memory request
//  instr_addr_o    out  32  word address, bits [1:0] = 0
//  instr_gnt_i     in   1   request accepted
//  instr_rvalid_i  in   1   response data valid
//  instr_rdata_i   in   32  response data
//  busy_o          out  1   request pending or outstanding
// BEHAVIOUR
//  Reset values: instr_req_o=0, valid_o=0, busy_o=0, addr_o=0, rdata_o=0.
//    FIFO empty, FSM=IDLE, fetch_addr_q=0.
//  Reset asserted mid-transaction drops all state immediately. A late rvalid after reset is ignored (FSM=IDLE).
//  Max one outstanding transaction.
//  space = fewer than DEPTH words held plus outstanding.
//  FSM:
//    IDLE:        instr_req_o = req_i & space.
//                 gnt -> WAIT_RVALID; no gnt -> WAIT_GNT.
//    WAIT_GNT:    instr_req_o held 1.
//                 gnt -> WAIT_RVALID.
//                 branch_i retargets instr_addr_o; the request stays high.
//    WAIT_RVALID: on rvalid, push the word.
//                   If req_i & space, issue the next request in the same cycle (gnt -> stay, else WAIT_GNT).
//                   Otherwise -> IDLE.
//                 branch_i without rvalid -> WAIT_ABORTED.
//                 branch_i with rvalid -> drop the word, then issue as IDLE.
//    WAIT_ABORTED: instr_req_o=0. On rvalid, discard the data, then issue the branch-target request as IDLE does.
//  Addressing: instr_addr_o = branch_i ? {addr_i[31:2],2'b00} : fetch_addr_q.
//    On gnt, fetch_addr_q <= instr_addr_o + 4; the 32-bit wrap past 0xFFFFFFFC to 0 is allowed.
//  Branch: in the same cycle, FIFO flushed, valid_o=0, addr_o <= addr_i.
//    branch_i has priority over ready_i and over a push.
//  Realign, with e0/e1 the oldest two words:
//    addr_o[1]=0: rdata_o = e0.
//    addr_o[1]=1: rdata_o = {e1[15:0], e0[31:16]}.
//  Compressed means rdata_o[1:0] != 2'b11.
//  valid_o conditions:
//    addr_o[1]=0 and e0 valid.
//    addr_o[1]=1 and e0 valid and (compressed or e1 valid).
//  Consume, on valid_o & ready_i:
//    addr_o += compressed ? 2 : 4.
//    Pop e0 if the new addr_o crosses out of e0 (aligned 32-bit, or unaligned of either size).
//    Pop and push in the same cycle are allowed; the FIFO count is unchanged.
//  An rvalid arriving when the FIFO is full cannot occur (space is reserved at issue); an assertion checks it.
//  req_i low: the outstanding transaction completes and the data is pushed; no new request. The FIFO keeps draining.
//  busy_o = (FSM != IDLE) | instr_req_o.
// TESTING
//  - Reset, then req_i=1, branch_i=1, addr_i=0x80, gnt/rvalid one cycle later.
//    Expect instr_addr_o=0x80,0x84,... and valid_o with addr_o=0x80, rdata_o equal to mem[0x80].
//  - Stream 0x0001_4501 (two compressed) then 0x0000_0013. Expect 3 transfers with addr_o 0x80, 0x82, 0x84.
//  - Branch to 0x86 where the word at 0x84 is 0x0513_xxxx and the word at 0x88 is 0x....0000.
//    Expect fetch at 0x84 then 0x88, one transfer at addr_o=0x86 with rdata_o = {mem88[15:0], mem84[31:16]}.
//    valid_o stays 0 until 0x88 arrives.
//  - Branch to 0x200 during WAIT_RVALID for 0x90. Expect the 0x90 data discarded,
//    the next request at 0x200, and no valid_o with addr_o=0x90.
//  - Hold ready_i=0 with gnt always 1. Expect the FIFO to fill to DEPTH, instr_req_o to drop,
//    and no overflow; releasing ready_i resumes fetching.
//  - Assert rst_n=0 with a request outstanding. Expect all outputs 0 asynchronously;
//    a stray rvalid after reset is ignored.

Source files
------------

// File: rtl/flexbex_ibex_prefetch_queue.sv
// Instruction prefetcher: fetches 32-bit words over req/gnt/rvalid into a small FIFO
// and realigns them so one RV32IC instruction (16 or 32 bit) is offered per transfer.
module flexbex_ibex_prefetch_queue #(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned UW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_GNT,
    S_WAIT_RVALID,
    S_WAIT_ABORTED
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_fetch_addr;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_mem     [DEPTH];
  logic [AW-1:0] w_mem_nxt [DEPTH];

  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic          w_space;
  logic          w_compressed;
  logic          w_valid;
  logic          w_consume;
  logic [UW-1:0] w_used;
  logic [CW-1:0] w_wr_idx;
  logic [AW-1:0] w_branch_addr;

  // The outstanding word already owns a FIFO slot; a branch frees the whole FIFO.
  assign w_used  = {1'b0, r_cnt} + UW'(r_state == S_WAIT_RVALID);
  assign w_space = branch_i | (w_used < UW'(DEPTH));

  assign w_branch_addr = {addr_i[31:2], 2'b00};
  assign instr_addr_o  = branch_i ? w_branch_addr : r_fetch_addr;
  assign instr_req_o   = w_req & rst_n;
  assign busy_o        = (r_state != S_IDLE) | instr_req_o;

  // Realignment: an odd halfword PC takes its upper half from the next word.
  assign rdata_o      = r_addr[1] ? {r_mem[1][15:0], r_mem[0][31:16]} : r_mem[0];
  assign w_compressed = (rdata_o[1:0] != 2'b11);
  assign w_valid      = (r_cnt != '0) && (!r_addr[1] || w_compressed || (r_cnt > CW'(1)));
  assign valid_o      = w_valid & ~branch_i;
  assign w_consume    = valid_o & ready_i;
  assign w_pop        = w_consume & (r_addr[1] | ~w_compressed);
  assign w_wr_idx     = r_cnt - CW'(w_pop);

  // Fetch FSM: at most one transaction in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE:     w_req = req_i & w_space;
      S_WAIT_GNT: w_req = 1'b1;
      S_WAIT_RVALID: begin
        if (instr_rvalid_i) begin
          w_push      = ~branch_i;
          w_req       = req_i & w_space;
          w_state_nxt = S_IDLE;
        end else if (branch_i) begin
          w_state_nxt = S_WAIT_ABORTED;
        end
      end
      S_WAIT_ABORTED: begin
        if (instr_rvalid_i) begin
          w_req       = req_i & w_space;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_req) begin
      w_state_nxt = instr_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
    end
  end

  // FIFO as a shift register: entry 0 is always the oldest word.
  always_comb begin
    w_mem_nxt = r_mem;
    if (w_pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        w_mem_nxt[i] = r_mem[i+1];
      end
    end
    if (w_push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == w_wr_idx) begin
          w_mem_nxt[i] = instr_rdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_fetch_addr <= '0;
      r_addr       <= '0;
      r_cnt        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_mem   <= w_mem_nxt;
      if (instr_req_o & instr_gnt_i) begin
        r_fetch_addr <= instr_addr_o + 32'd4;
      end else if (branch_i) begin
        r_fetch_addr <= w_branch_addr;
      end
      if (branch_i) begin
        r_addr <= addr_i;
      end else if (w_consume) begin
        r_addr <= r_addr + (w_compressed ? 32'd2 : 32'd4);
      end
      if (branch_i) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  assign addr_o = r_addr;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_cnt == CW'(DEPTH))));

endmodule
